// File: rtl/cbus_arb_pkg.sv
// Shared cbus request/response types plus the arbiter's state and owner-index types.
package cbus_arb_pkg;

    localparam int CBUS_ARB_MAX_NREQ = 8;

    typedef enum logic [1:0] {
        MLEN1 = 2'd0,
        MLEN2 = 2'd1,
        MLEN4 = 2'd2,
        MLEN8 = 2'd3
    } cbus_len_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [31:0] addr;
        logic [2:0]  size;
        cbus_len_t   len;
        logic [31:0] data;
        logic [3:0]  strobe;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Sized for the largest legal requester count; the top exports only the low bits.
    typedef logic [$clog2(CBUS_ARB_MAX_NREQ)-1:0] arb_idx_t;

    function automatic arb_idx_t arb_idx_wrap_inc(arb_idx_t i, int n);
        return (i == arb_idx_t'(n - 1)) ? '0 : i + arb_idx_t'(1);
    endfunction

endpackage

// File: rtl/cbus_arb_pick.sv
// Combinational rotating-priority picker: first valid requester at or after start wins.
module cbus_arb_pick
    import cbus_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] valid,
    input  arb_idx_t        start,
    output arb_idx_t        idx,
    output logic            any
);
    localparam int IW = $bits(arb_idx_t);

    logic [NREQ-1:0] rot;
    arb_idx_t        off;
    logic [IW:0]     idx_sum;

    // rot[k] is the request k positions after start, wrapping modulo NREQ.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
        logic [IW:0]   sum;
        logic [IW-1:0] pos;
        logic          rot_bit;

        assign sum = {1'b0, start} + (IW+1)'(gi);
        assign pos = (sum >= (IW+1)'(NREQ)) ? IW'(sum - (IW+1)'(NREQ)) : sum[IW-1:0];

        always_comb begin
            rot_bit = 1'b0;
            for (int j = 0; j < NREQ; j++) begin
                if (pos == IW'(j)) rot_bit = valid[j];
            end
        end

        assign rot[gi] = rot_bit;
    end

    always_comb begin
        off = '0;
        any = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = IW'(k);
                any = 1'b1;
            end
        end
    end

    assign idx_sum = {1'b0, start} + {1'b0, off};
    assign idx     = (idx_sum >= (IW+1)'(NREQ)) ? IW'(idx_sum - (IW+1)'(NREQ)) : idx_sum[IW-1:0];

endmodule

// File: rtl/cbus_arbiter.sv
// N-to-1 cbus arbiter: one transaction owns the downstream port from grant until ready+last.
// Define CBUS_ARB_RR_EN for round-robin priority; fixed lowest-index priority otherwise.
module cbus_arbiter
    import cbus_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  cbus_req_t  [NREQ-1:0]      ireqs,
    output cbus_resp_t [NREQ-1:0]      iresps,
    output cbus_req_t                  oreq,
    input  cbus_resp_t                 oresp,
    output logic                       busy,
    output logic [$clog2(NREQ)-1:0]    owner
);
    localparam int OW = $clog2(NREQ);

    arb_state_t      state_reg, state_next;
    arb_idx_t        owner_reg, owner_next;
    arb_idx_t        pick_idx;
    arb_idx_t        start_ptr;
    logic            pick_any;
    logic            done;
    logic [NREQ-1:0] valid_vec;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_valid
        assign valid_vec[gi] = ireqs[gi].valid;
    end

    assign done = (state_reg == ARB_BUSY) && oresp.ready && oresp.last;

`ifdef CBUS_ARB_RR_EN
    arb_idx_t ptr_reg, ptr_next;

    // Search resumes just past whoever finished last.
    assign ptr_next = done ? arb_idx_wrap_inc(owner_reg, NREQ) : ptr_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) ptr_reg <= '0;
        else         ptr_reg <= ptr_next;
    end

    assign start_ptr = ptr_reg;
`else
    assign start_ptr = '0;
`endif

    cbus_arb_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .valid (valid_vec),
        .start (start_ptr),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= ARB_IDLE;
            owner_reg <= '0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        case (state_reg)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_next = ARB_BUSY;
                    owner_next = pick_idx;
                end
            end
            ARB_BUSY: begin
                // A dropped valid mid-burst is forwarded, not treated as an abort.
                if (done) state_next = ARB_IDLE;
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_reg == ARB_BUSY);
        oreq = '0;
        if (state_reg == ARB_BUSY) begin
            for (int i = 0; i < NREQ; i++) begin
                if (owner_reg == arb_idx_t'(i)) oreq = ireqs[i];
            end
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_resp
        assign iresps[gi] = ((state_reg == ARB_BUSY) && (owner_reg == arb_idx_t'(gi))) ? oresp : '0;
    end

    assign owner = owner_reg[OW-1:0];

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed scenarios plus random traffic checked against a transaction-level arbiter model.
module tb_cbus_arbiter;
    import cbus_arb_pkg::*;

    localparam int NREQ = 2;
    localparam int OW   = $clog2(NREQ);

    logic                    clk;
    logic                    resetn;
    cbus_req_t  [NREQ-1:0]   ireqs;
    cbus_resp_t [NREQ-1:0]   iresps;
    cbus_req_t               oreq;
    cbus_resp_t              oresp;
    logic                    busy;
    logic [OW-1:0]           owner;

    cbus_arbiter #(.NREQ(NREQ)) dut (
        .clk    (clk),
        .resetn (resetn),
        .ireqs  (ireqs),
        .iresps (iresps),
        .oreq   (oreq),
        .oresp  (oresp),
        .busy   (busy),
        .owner  (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: a transaction is either in flight (owned by m_owner) or not.
    int m_busy  = 0;
    int m_owner = 0;
    int m_ptr   = 0;

    int prev_busy   = 0;
    int busy_cycles = 0;
    int grants[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy    = 0;
        m_owner   = 0;
        m_ptr     = 0;
        prev_busy = 0;
    endtask

    // Called at a falling edge with inputs already applied; ends at the next falling edge.
    task automatic step();
        int n_busy, n_owner, n_ptr;
        cbus_resp_t exp_resp;
        #1;
        chk("busy",  128'(busy),  128'(m_busy != 0));
        chk("owner", 128'(owner), 128'(m_owner));
        chk("oreq",  128'(oreq),  m_busy != 0 ? 128'(ireqs[m_owner]) : 128'(0));
        for (int i = 0; i < NREQ; i++) begin
            exp_resp = (m_busy != 0 && i == m_owner) ? oresp : '0;
            chk($sformatf("iresps[%0d]", i), 128'(iresps[i]), 128'(exp_resp));
        end
        if (busy === 1'b1) busy_cycles++;
        if (busy === 1'b1 && prev_busy == 0) grants.push_back(int'(owner));
        prev_busy = (busy === 1'b1) ? 1 : 0;

        n_busy  = m_busy;
        n_owner = m_owner;
        n_ptr   = m_ptr;
        if (m_busy == 0) begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                if (ireqs[(m_ptr + k) % NREQ].valid) begin
                    n_busy  = 1;
                    n_owner = (m_ptr + k) % NREQ;
                end
            end
        end else if (oresp.ready && oresp.last) begin
            n_busy = 0;
`ifdef CBUS_ARB_RR_EN
            n_ptr = (m_owner + 1) % NREQ;
`endif
        end
        @(posedge clk);
        m_busy  = n_busy;
        m_owner = n_owner;
        m_ptr   = n_ptr;
        @(negedge clk);
    endtask

    function automatic cbus_req_t mk_req(input logic wr, input cbus_len_t len, input logic [31:0] addr,
                                         input logic [3:0] strobe);
        cbus_req_t r;
        r          = '0;
        r.valid    = 1'b1;
        r.is_write = wr;
        r.addr     = addr;
        r.size     = 3'd2;
        r.len      = len;
        r.data     = addr ^ 32'hA5A5_0000;
        r.strobe   = strobe;
        return r;
    endfunction

    function automatic cbus_resp_t mk_resp(input logic rdy, input logic lst, input logic [31:0] d);
        cbus_resp_t r;
        r.ready = rdy;
        r.last  = lst;
        r.data  = d;
        return r;
    endfunction

    initial begin
        int exp_order[4];
        resetn = 1'b0;
        ireqs  = '0;
        oresp  = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset_busy",  128'(busy),  128'(0));
        chk("reset_owner", 128'(owner), 128'(0));
        chk("reset_oreq",  128'(oreq),  128'(0));
        chk("reset_iresp1", 128'(iresps[1]), 128'(0));
        resetn = 1'b1;
        model_reset();
        @(negedge clk);

        // ICache MLEN2 read, ready on both beats, last on the second.
        ireqs[0] = mk_req(1'b0, MLEN2, 32'h0000_0100, 4'h0);
        step();
        oresp = mk_resp(1'b1, 1'b0, 32'h1111_0001);
        step();
        oresp = mk_resp(1'b1, 1'b1, 32'h1111_0002);
        step();
        ireqs = '0;
        oresp = '0;
        step();

        // ICache and DCache request together; DCache waits for the ICache last.
        grants.delete();
        ireqs[0] = mk_req(1'b0, MLEN1, 32'h0000_0200, 4'h0);
        ireqs[1] = mk_req(1'b0, MLEN1, 32'h0000_0300, 4'h0);
        step();
        oresp = mk_resp(1'b1, 1'b1, 32'h2222_0001);
        step();
        ireqs[0].valid = 1'b0;
        oresp = '0;
        step();
        oresp = mk_resp(1'b1, 1'b1, 32'h2222_0002);
        step();
        ireqs = '0;
        oresp = '0;
        step();
        chk("order_031_n",  128'(grants.size()), 128'(2));
        chk("order_031_g0", 128'(grants[0]), 128'(0));
        chk("order_031_g1", 128'(grants[1]), 128'(1));

        // Both held valid across four single-beat transactions.
        grants.delete();
`ifdef CBUS_ARB_RR_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        ireqs[0] = mk_req(1'b0, MLEN1, 32'h0000_0400, 4'h0);
        ireqs[1] = mk_req(1'b1, MLEN1, 32'h0000_0500, 4'hF);
        oresp    = mk_resp(1'b1, 1'b1, 32'h3333_0000);
        for (int t = 0; t < 8; t++) step();
        ireqs = '0;
        oresp = '0;
        step();
        chk("order_032_n", 128'(grants.size()), 128'(4));
        for (int i = 0; i < 4; i++)
            chk($sformatf("order_032_g%0d", i), 128'(grants[i]), 128'(exp_order[i]));

        // DCache single-beat write completes in one BUSY cycle.
        busy_cycles = 0;
        ireqs[1] = mk_req(1'b1, MLEN1, 32'h0000_0600, 4'hF);
        oresp    = mk_resp(1'b1, 1'b1, 32'h0);
        step();
        ireqs[1].valid = 1'b0;
        #1;
        chk("wr_busy",     128'(busy),          128'(1));
        chk("wr_is_write", 128'(oreq.is_write), 128'(1));
        chk("wr_strobe",   128'(oreq.strobe),   128'(4'hF));
        step();
        oresp = '0;
        step();
        chk("wr_busy_cycles", 128'(busy_cycles), 128'(1));

        // Reset in the third beat of a DCache MLEN4 burst.
        ireqs[1] = mk_req(1'b0, MLEN4, 32'h0000_0700, 4'h0);
        step();
        oresp = mk_resp(1'b1, 1'b0, 32'h4444_0000);
        step();
        step();
        #1;
        chk("rst_pre_owner", 128'(owner), 128'(1));
        resetn = 1'b0;
        #1;
        chk("rst_busy",   128'(busy),       128'(0));
        chk("rst_ovalid", 128'(oreq.valid), 128'(0));
        chk("rst_owner",  128'(owner),      128'(0));
        model_reset();
        ireqs = '0;
        oresp = '0;
        @(negedge clk);
        resetn = 1'b1;

        // Owner drops valid mid-burst: still BUSY, valid=0 forwarded.
        ireqs[0] = mk_req(1'b0, MLEN4, 32'h0000_0800, 4'h0);
        step();
        oresp = mk_resp(1'b1, 1'b0, 32'h5555_0000);
        step();
        ireqs[0].valid = 1'b0;
        #1;
        chk("drop_busy",   128'(busy),       128'(1));
        chk("drop_ovalid", 128'(oreq.valid), 128'(0));
        step();
        oresp = mk_resp(1'b1, 1'b1, 32'h5555_0001);
        step();
        ireqs = '0;
        oresp = '0;
        step();

        // Random traffic.
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                ireqs[i].valid    = ($urandom_range(0, 99) < 45);
                ireqs[i].is_write = 1'($urandom);
                ireqs[i].addr     = $urandom;
                ireqs[i].size     = 3'($urandom);
                ireqs[i].len      = cbus_len_t'($urandom_range(0, 3));
                ireqs[i].data     = $urandom;
                ireqs[i].strobe   = 4'($urandom);
            end
            oresp.ready = ($urandom_range(0, 99) < 60);
            oresp.last  = ($urandom_range(0, 99) < 35);
            oresp.data  = $urandom;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
